// File: rtl/speed_ramp_controller_pkg.sv
// Shared types and constants for the speed ramp controller.
// The optional target clamp is selected with the SPEED_CLAMP_EN macro in the top module.
package speed_ctrl_pkg;

  localparam int unsigned SPEED_W = 4;

  typedef logic [SPEED_W-1:0] speed_t;

  localparam speed_t SPEED_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2,
    ESTOP     = 2'd3
  } ramp_state_t;

endpackage

// File: rtl/speed_ramp_controller_if.sv
// Target-speed command handshake between the host command decoder and the ramp controller.
interface speed_cmd_if;
  import speed_ctrl_pkg::*;

  logic   cmd_valid;
  speed_t cmd_speed;
  logic   cmd_ready;

  modport master (
    output cmd_valid,
    output cmd_speed,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_speed,
    output cmd_ready
  );

endinterface

// File: rtl/speed_ramp_controller_ramp_tick_gen.sv
// Free-running step timer for the ramp controller; step_tick is high while the count is all-ones.
module ramp_tick_gen #(
  parameter int unsigned RAMP_DIV_WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic step_tick
);

  typedef logic [RAMP_DIV_WIDTH-1:0] cnt_t;

  cnt_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + cnt_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign step_tick = &cnt_q;

endmodule

// File: rtl/speed_ramp_controller.sv
// Slews the PWM speed word one step per 2^RAMP_DIV_WIDTH clocks toward the commanded target, with estop.
// Define SPEED_CLAMP_EN to limit accepted targets to MAX_SPEED.
module speed_ramp_controller
  import speed_ctrl_pkg::*;
#(
  parameter int unsigned       RAMP_DIV_WIDTH = 16,
  parameter logic [SPEED_W-1:0] MAX_SPEED     = 4'd15
) (
  input  logic               FPGA_clk,
  input  logic               FPGA_reset,
  speed_cmd_if.slave         cmd,
  input  logic               estop,
  output logic [SPEED_W-1:0] speed,
  output logic               ramp_busy,
  output logic               at_target
);

`ifdef SPEED_CLAMP_EN
  localparam bit CLAMP_ON = 1'b1;
`else
  localparam bit CLAMP_ON = 1'b0;
`endif

  ramp_state_t state_q, state_d;
  speed_t      speed_q, speed_d;
  speed_t      target_q, target_d;
  speed_t      cmd_target;
  logic        accept;
  logic        timer_clr;
  logic        timer_en;
  logic        step_tick;

  assign cmd_target    = (CLAMP_ON && (cmd.cmd_speed > MAX_SPEED)) ? MAX_SPEED : cmd.cmd_speed;
  assign cmd.cmd_ready = (state_q != ESTOP) && !estop;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  ramp_tick_gen #(
    .RAMP_DIV_WIDTH (RAMP_DIV_WIDTH)
  ) u_tick (
    .clk       (FPGA_clk),
    .rst       (FPGA_reset),
    .clr       (timer_clr),
    .en        (timer_en),
    .step_tick (step_tick)
  );

  // Priority: estop, then ESTOP exit, then a new command, then the ramp step.
  always_comb begin
    state_d   = state_q;
    speed_d   = speed_q;
    target_d  = target_q;
    timer_clr = 1'b0;
    timer_en  = 1'b0;
    if (estop) begin
      speed_d   = SPEED_ZERO;
      target_d  = SPEED_ZERO;
      state_d   = ESTOP;
      timer_clr = 1'b1;
    end else if (state_q == ESTOP) begin
      state_d   = IDLE;
      timer_clr = 1'b1;
    end else if (accept) begin
      target_d  = cmd_target;
      timer_clr = 1'b1;
      if (cmd_target > speed_q) begin
        state_d = RAMP_UP;
      end else if (cmd_target < speed_q) begin
        state_d = RAMP_DOWN;
      end else begin
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        RAMP_UP: begin
          timer_en = 1'b1;
          if (step_tick) begin
            speed_d = speed_q + speed_t'(1);
            if (speed_d == target_q) state_d = IDLE;
          end
        end
        RAMP_DOWN: begin
          timer_en = 1'b1;
          if (step_tick) begin
            speed_d = speed_q - speed_t'(1);
            if (speed_d == target_q) state_d = IDLE;
          end
        end
        default: timer_clr = 1'b1;
      endcase
    end
  end

  always_ff @(posedge FPGA_clk) begin
    if (FPGA_reset) begin
      state_q  <= IDLE;
      speed_q  <= SPEED_ZERO;
      target_q <= SPEED_ZERO;
    end else begin
      state_q  <= state_d;
      speed_q  <= speed_d;
      target_q <= target_d;
    end
  end

  assign speed     = speed_q;
  assign ramp_busy = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);
  assign at_target = (state_q == IDLE);

endmodule

// File: tb/tb_speed_ramp_controller.sv
// Scoreboard bench for speed_ramp_controller: a cycle-level reference model pushes expected outputs, a monitor checks them.
module tb_speed_ramp_controller;
  import speed_ctrl_pkg::*;

  localparam int unsigned DIV_W     = 2;
  localparam int          STEP_CYC  = 1 << DIV_W;
  localparam logic [3:0]  MAX_SPD   = 4'd10;

  typedef struct {
    int   spd;
    logic busy;
    logic at;
    logic rdy;
  } exp_t;

  logic       FPGA_clk = 1'b0;
  logic       FPGA_reset;
  logic       estop;
  logic [3:0] speed;
  logic       ramp_busy;
  logic       at_target;

  speed_cmd_if cmd_if ();

  speed_ramp_controller #(
    .RAMP_DIV_WIDTH (DIV_W),
    .MAX_SPEED      (MAX_SPD)
  ) dut (
    .FPGA_clk   (FPGA_clk),
    .FPGA_reset (FPGA_reset),
    .cmd        (cmd_if),
    .estop      (estop),
    .speed      (speed),
    .ramp_busy  (ramp_busy),
    .at_target  (at_target)
  );

  always #5 FPGA_clk = ~FPGA_clk;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];

  // Reference model: speed and target as integers, a cycle count since the last accept/step.
  int m_speed, m_target, m_cnt;
  bit m_stopped;

  function automatic int clamp_cmd(input int c);
`ifdef SPEED_CLAMP_EN
    return (c > int'(MAX_SPD)) ? int'(MAX_SPD) : c;
`else
    return c;
`endif
  endfunction

  task automatic model_reset();
    m_speed = 0; m_target = 0; m_cnt = 0; m_stopped = 0;
  endtask

  task automatic model_edge(input bit r, input bit e, input bit v, input int c);
    bit rdy;
    rdy = !m_stopped && !e;
    if (r) begin
      model_reset();
    end else if (e) begin
      m_speed = 0; m_target = 0; m_cnt = 0; m_stopped = 1;
    end else if (m_stopped) begin
      m_stopped = 0;
    end else if (v && rdy) begin
      m_target = clamp_cmd(c);
      m_cnt    = 0;
    end else if (m_speed != m_target) begin
      m_cnt++;
      if (m_cnt == STEP_CYC) begin
        m_speed += (m_target > m_speed) ? 1 : -1;
        m_cnt = 0;
      end
    end
  endtask

  // Drive one cycle: expectation for the outputs visible this cycle, then the clock edge.
  task automatic step(input bit r, input bit e, input bit v, input int c);
    exp_t x;
    FPGA_reset = r; estop = e; cmd_if.cmd_valid = v; cmd_if.cmd_speed = 4'(c);
    x.spd  = m_speed;
    x.busy = !m_stopped && (m_speed != m_target);
    x.at   = !m_stopped && (m_speed == m_target);
    x.rdy  = !m_stopped && !e;
    sb_q.push_back(x);
    @(posedge FPGA_clk);
    model_edge(r, e, v, c);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  // Monitor: outputs are presented every cycle; compare against the oldest pending expectation.
  initial begin
    exp_t x;
    forever begin
      @(negedge FPGA_clk);
      if (sb_q.size() != 0) begin
        x = sb_q.pop_front();
        checks++;
        if (int'(speed) !== x.spd) begin
          failures++;
          $display("FAIL speed t=%0t got=%0d exp=%0d", $time, speed, x.spd);
        end
        checks++;
        if (ramp_busy !== x.busy) begin
          failures++;
          $display("FAIL ramp_busy t=%0t got=%b exp=%b", $time, ramp_busy, x.busy);
        end
        checks++;
        if (at_target !== x.at) begin
          failures++;
          $display("FAIL at_target t=%0t got=%b exp=%b", $time, at_target, x.at);
        end
        checks++;
        if (cmd_if.cmd_ready !== x.rdy) begin
          failures++;
          $display("FAIL cmd_ready t=%0t got=%b exp=%b", $time, cmd_if.cmd_ready, x.rdy);
        end
      end
    end
  end

  initial begin
    FPGA_reset = 1'b1; estop = 1'b0; cmd_if.cmd_valid = 1'b0; cmd_if.cmd_speed = 4'd0;
    repeat (2) @(posedge FPGA_clk);
    #1;
    model_reset();

    // Command equal to current speed, then a ramp up to 5.
    step(0, 0, 1, 0);  idle(3);
    step(0, 0, 1, 5);  idle(22);
    // Down toward 2, reverse mid-descent toward 9.
    step(0, 0, 1, 2);  idle(9);
    step(0, 0, 1, 9);  idle(14);
    // Estop together with a command, then release.
    step(0, 1, 1, 12); step(0, 1, 0, 0);
    step(0, 0, 1, 7);  step(0, 0, 1, 7); idle(10);
    // Reset mid-ramp.
    step(0, 0, 1, 14); idle(6);
    step(1, 0, 1, 3);  idle(3);
    // Full-scale target: clamped or reaching 15 without wrap.
    step(0, 0, 1, 15); idle(66);
    step(0, 0, 1, 0);  idle(66);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 9) == 0, int'($urandom_range(0, 15)));
    end
    idle(4);

    @(negedge FPGA_clk);
    @(negedge FPGA_clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
